servo_pwm_array: RTL
====================

SERVO_PWM_ARRAY -- requirements
Module: servo_pwm_array

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent servo channels.
REQ-002 Parameter ANGLE_W, default 8: width of each per-channel angle command.
REQ-003 Parameter FRAME_CYCLES, default 1000000: PWM frame length in clk cycles (20 ms at 50 MHz).
REQ-004 Parameter BASE_CYCLES, default 50000: pulse width for angle 0 (1.0 ms).
REQ-005 Parameter CYC_PER_STEP, default 275: additional pulse cycles per angle unit (5.5 us).
REQ-006 Parameter MAX_ANGLE, default 180: largest legal angle; larger commands are clamped.
REQ-007 Parameter SLEW_STEP, default 0: maximum change of active angle per frame; 0 disables slew limiting.
REQ-008 clk  input  1  single system clock; all logic is clocked on its rising edge.
REQ-009 rst  input  1  synchronous, active-high reset.
REQ-010 angle_in  input  NUM_CH*ANGLE_W  packed angle commands, channel i at bits [i*ANGLE_W +: ANGLE_W].
REQ-011 upd_valid  input  1  request to load angle_in as the new command set.
REQ-012 upd_ready  output  1  high when a new command set can be accepted.
REQ-013 ch_en  input  NUM_CH  per-channel output enable.
REQ-014 servo_out  output  NUM_CH  registered PWM outputs.
REQ-015 frame_start  output  1  one-cycle pulse marking the start of each frame.

Function
REQ-016 The frame counter SHALL count 0..FRAME_CYCLES-1, wrap to 0, and be $clog2(FRAME_CYCLES) bits wide; the cycle with counter==0 is the frame boundary.
REQ-017 The design SHALL require BASE_CYCLES + MAX_ANGLE*CYC_PER_STEP < FRAME_CYCLES and MAX_ANGLE < 2**ANGLE_W; the bench checks both at elaboration.
REQ-018 The update handshake SHALL use two states: IDLE (upd_ready=1) and PENDING (upd_ready=0).
REQ-019 In IDLE, upd_valid=1 SHALL capture angle_in, with each channel clamped to MAX_ANGLE, into a pending register and move to PENDING on the next cycle.
REQ-020 In PENDING, upd_valid SHALL be ignored; at the next frame boundary the pending set SHALL be copied to the target angles and the state SHALL return to IDLE.
REQ-021 A command accepted in the frame-boundary cycle itself SHALL apply at the following boundary, not the current one.
REQ-022 At each frame boundary, each active angle SHALL step toward its target by at most SLEW_STEP, or equal the target when SLEW_STEP=0 or |target-active| <= SLEW_STEP.
REQ-023 At each frame boundary, width[i] = BASE_CYCLES + active[i]*CYC_PER_STEP SHALL be computed in counter width, using the active value after that boundary's slew step, and held for the frame.
REQ-024 ch_en SHALL be sampled only at the frame boundary, so enabling or disabling a channel never produces a truncated pulse.
REQ-025 servo_out[i] SHALL be high for exactly width[i] consecutive cycles per frame when enabled, rising the cycle after counter==0, and low for the whole frame when disabled.
REQ-026 frame_start SHALL be high for one cycle, the cycle after counter==0, aligned with the servo_out rising edge.

Reset
REQ-027 While rst=1: counter=0, servo_out=0, frame_start=0, state=IDLE, upd_ready=1, latched enables=0, active, target and pending angles=MAX_ANGLE/2 (90).
REQ-028 rst asserted mid-pulse SHALL force servo_out low on the next clk edge; after release the counter SHALL restart at 0 and the first frame SHALL begin with a boundary.

Verification
REQ-029 Reset, ch_en=4'b1111, angle_in all 0 with upd_valid for 1 cycle -> first frame after reset: width 74750 on all channels (angle 90); from the frame after acceptance: 50000-cycle pulses, period 1000000.
REQ-030 Channel 2 commanded 180 and channel 3 commanded 200 -> both produce 99500-cycle pulses (clamp).
REQ-031 SLEW_STEP=10, from reset (active 90), command 0 -> successive frame widths 72000, 69250, ..., 50000, reaching angle 0 after 9 frames.
REQ-032 Second upd_valid while PENDING -> upd_ready=0, command ignored; first command applies at the boundary; upd_ready returns to 1 the following cycle.
REQ-033 ch_en[1] deasserted mid-pulse -> current pulse completes at full width; servo_out[1] stays low for the next full frame.
REQ-034 rst pulsed for 1 cycle mid-pulse -> servo_out=0 the next cycle; frame_start asserts 1 cycle after reset release, then every 1000000 cycles.

Source files
------------

// File: rtl/servo_pwm_array_if.sv
// Command/output bundle for servo_pwm_array.
//   angle_in    : packed per-channel angle commands, channel i at [i*ANGLE_W +: ANGLE_W]
//   upd_valid   : request to load angle_in as the next command set
//   upd_ready   : a new command set can be accepted
//   ch_en       : per-channel output enable (taken at frame boundaries)
//   servo_out   : registered PWM outputs
//   frame_start : one-cycle pulse marking the start of each frame
interface servo_pwm_array_if #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned ANGLE_W = 8
);
  logic [NUM_CH*ANGLE_W-1:0] angle_in;
  logic                      upd_valid;
  logic                      upd_ready;
  logic [NUM_CH-1:0]         ch_en;
  logic [NUM_CH-1:0]         servo_out;
  logic                      frame_start;

  modport master (
    output angle_in, upd_valid, ch_en,
    input  upd_ready, servo_out, frame_start
  );

  modport slave (
    input  angle_in, upd_valid, ch_en,
    output upd_ready, servo_out, frame_start
  );
endinterface

// File: rtl/servo_pwm_array.sv
// Multi-channel hobby-servo PWM generator with a frame-synchronous command
// update, angle clamping and optional per-frame slew limiting.
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : servo_pwm_array_if slave (commands in, PWM and status out)
module servo_pwm_array #(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned ANGLE_W      = 8,
  parameter int unsigned FRAME_CYCLES = 1000000,
  parameter int unsigned BASE_CYCLES  = 50000,
  parameter int unsigned CYC_PER_STEP = 275,
  parameter int unsigned MAX_ANGLE    = 180,
  parameter int unsigned SLEW_STEP    = 0
) (
  input logic               clk,
  input logic               rst,
  servo_pwm_array_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(FRAME_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [CNT_W-1:0]   W_BASE   = CNT_W'(BASE_CYCLES);
  localparam logic [CNT_W-1:0]   W_STEP   = CNT_W'(CYC_PER_STEP);
  localparam logic [ANGLE_W-1:0] ANG_MAX  = ANGLE_W'(MAX_ANGLE);
  localparam logic [ANGLE_W-1:0] ANG_MID  = ANGLE_W'(MAX_ANGLE / 2);
  localparam logic [ANGLE_W-1:0] ANG_SLEW = ANGLE_W'(SLEW_STEP);

  typedef enum logic {ST_IDLE, ST_PENDING} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt;
  logic               boundary;
  logic               load, apply;
  logic [NUM_CH-1:0]  en;
  logic [NUM_CH-1:0]  out_next;

  logic [ANGLE_W-1:0] pending     [NUM_CH];
  logic [ANGLE_W-1:0] target      [NUM_CH];
  logic [ANGLE_W-1:0] active      [NUM_CH];
  logic [ANGLE_W-1:0] clamped     [NUM_CH];
  logic [ANGLE_W-1:0] target_next [NUM_CH];
  logic [ANGLE_W-1:0] active_next [NUM_CH];
  logic [CNT_W-1:0]   width       [NUM_CH];
  logic [CNT_W-1:0]   width_next  [NUM_CH];

  // Frame boundary is the cycle in which the counter reads zero.
  assign boundary = (cnt == '0);

  // Frame counter 0..FRAME_CYCLES-1.
  always_ff @(posedge clk) begin
    if (rst)                   cnt <= '0;
    else if (cnt == CNT_LAST)  cnt <= '0;
    else                       cnt <= cnt + CNT_W'(1);
  end

  // Update handshake state register; upd_ready mirrors the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      bus.upd_ready <= 1'b1;
    end else begin
      state         <= state_next;
      bus.upd_ready <= (state_next == ST_IDLE);
    end
  end

  // Handshake next-state: capture in IDLE, hand over at the next boundary.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    apply      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.upd_valid) begin
          load       = 1'b1;
          state_next = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (boundary) begin
          apply      = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Per-channel clamp, slew step and pulse width for the upcoming frame.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      clamped[i] = (bus.angle_in[i*ANGLE_W +: ANGLE_W] > ANG_MAX) ?
                   ANG_MAX : bus.angle_in[i*ANGLE_W +: ANGLE_W];
      target_next[i] = apply ? pending[i] : target[i];
      if (SLEW_STEP == 0) begin
        active_next[i] = target_next[i];
      end else if (target_next[i] > active[i]) begin
        active_next[i] = ((target_next[i] - active[i]) > ANG_SLEW) ?
                         active[i] + ANG_SLEW : target_next[i];
      end else begin
        active_next[i] = ((active[i] - target_next[i]) > ANG_SLEW) ?
                         active[i] - ANG_SLEW : target_next[i];
      end
      width_next[i] = W_BASE + CNT_W'(active_next[i]) * W_STEP;
    end
  end

  // Angle registers; everything except the pending set moves only at a boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        pending[i] <= ANG_MID;
        target[i]  <= ANG_MID;
        active[i]  <= ANG_MID;
        width[i]   <= '0;
      end
      en <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (load) pending[i] <= clamped[i];
      end
      if (boundary) begin
        for (int i = 0; i < NUM_CH; i++) begin
          target[i] <= target_next[i];
          active[i] <= active_next[i];
          width[i]  <= width_next[i];
        end
        en <= bus.ch_en;
      end
    end
  end

  // Pulse level for the next cycle: on the boundary use the freshly computed
  // width and enable, otherwise stay high while cnt < width (width cycles total).
  always_comb begin
    out_next = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (boundary) out_next[i] = bus.ch_en[i] && (width_next[i] != '0);
      else          out_next[i] = en[i] && (cnt < width[i]);
    end
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.servo_out   <= '0;
      bus.frame_start <= 1'b0;
    end else begin
      bus.servo_out   <= out_next;
      bus.frame_start <= boundary;
    end
  end

endmodule
